// File: rtl/whac_game_ctrl_pkg.sv
// Shared types and helpers for the Whac-A-Mole game sequencer.
// State codes are shared with the timer and display blocks.
package whac_game_ctrl_pkg;

  typedef enum logic [4:0] {
    StIdle  = 5'd0,
    StSet   = 5'd1,
    StArm   = 5'd2,
    StPlay  = 5'd3,
    StOver  = 5'd4,
    StPause = 5'd5
  } state_e;

  localparam int unsigned NUM_HOLES = 8;
  localparam logic [7:0]  BCD_MAX   = 8'h99;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    logic [7:0] res;
    if (val == BCD_MAX) begin
      res = val;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Pick a hole from the random index, skipping the currently occupied one.
  function automatic logic [NUM_HOLES-1:0] next_mole(input logic [2:0] idx,
                                                     input logic [NUM_HOLES-1:0] cur);
    logic [2:0] sel;
    sel = idx;
    if (cur[sel]) begin
      sel = sel + 3'd1;
    end
    return 8'b0000_0001 << sel;
  endfunction

endpackage

// File: rtl/whac_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11.
module whac_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q <= seed;
    end else begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/whac_game_ctrl.sv
// Whac-A-Mole game sequencer: state bus to timer, mole placement, BCD score.
// Optional pause state enabled by defining WHAC_PAUSE_EN. rst_n is active-high.
module whac_game_ctrl
  import whac_game_ctrl_pkg::*;
#(
  parameter logic [31:0] MOLE_TICKS = 32'd50_000_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [7:0] hit,
  input  logic       timeover,
  output logic [4:0] state,
  output logic [7:0] mole,
  output logic [7:0] score
);

  state_e      state_q, state_d;
  logic [7:0]  mole_q, mole_d;
  logic [7:0]  score_q, score_d;
  logic [31:0] cnt_q, cnt_d;
  logic        start_q;
  logic [7:0]  hit_q;
  logic        start_e, pause_e;
  logic [7:0]  hit_e;
  logic [15:0] lfsr_q;
  logic [7:0]  new_mole;
  logic        hit_mole, expire;
  logic        unused_lfsr;

  whac_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:3];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      start_q <= 1'b0;
      hit_q   <= 8'h00;
    end else begin
      start_q <= btn_start;
      hit_q   <= hit;
    end
  end

`ifdef WHAC_PAUSE_EN
  logic pause_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= btn_pause;
    end
  end

  assign pause_e = btn_pause & ~pause_q;
`else
  logic unused_pause;

  assign unused_pause = btn_pause;
  assign pause_e      = 1'b0;
`endif

  assign start_e  = btn_start & ~start_q;
  assign hit_e    = hit & ~hit_q;
  assign hit_mole = |(hit_e & mole_q);
  assign expire   = (cnt_q == MOLE_TICKS - 32'd1);
  assign new_mole = next_mole(lfsr_q[2:0], mole_q);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_e) state_d = StSet;
      StSet:   if (start_e) state_d = StArm;
      StArm:   state_d = timeover ? StOver : StPlay;
      StPlay: begin
        if (timeover) begin
          state_d = StOver;
        end else if (pause_e) begin
          state_d = StPause;
        end
      end
      StOver:  if (start_e) state_d = StSet;
`ifdef WHAC_PAUSE_EN
      StPause: begin
        if (timeover) begin
          state_d = StOver;
        end else if (pause_e) begin
          state_d = StPlay;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mole_d  = mole_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    case (state_q)
      StArm: begin
        score_d = 8'h00;
        cnt_d   = 32'd0;
        mole_d  = timeover ? 8'h00 : new_mole;
      end
      StPlay: begin
        // timeover beats a same-cycle hit; a pause edge freezes everything
        if (timeover) begin
          mole_d = 8'h00;
        end else if (!pause_e) begin
          if (hit_mole) begin
            score_d = bcd_inc(score_q);
            mole_d  = new_mole;
            cnt_d   = 32'd0;
          end else if (expire) begin
            mole_d = new_mole;
            cnt_d  = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StPause: if (timeover) mole_d = 8'h00;
      default: mole_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mole_q  <= 8'h00;
      score_q <= 8'h00;
      cnt_q   <= 32'd0;
    end else begin
      mole_q  <= mole_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign mole  = mole_q;
  assign score = score_q;

endmodule

// File: tb/tb_whac_game_ctrl.sv
// Directed self-checking bench for whac_game_ctrl (MOLE_TICKS=4).
// Pause expectations follow WHAC_PAUSE_EN.
module tb_whac_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MT   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_pause, timeover;
  logic [7:0] hit;
  logic [4:0] state;
  logic [7:0] mole, score;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  m_mole, m_hitq, old_mole;
  int          m_cnt;

  whac_game_ctrl #(
    .MOLE_TICKS (32'd4),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .hit       (hit),
    .timeover  (timeover),
    .state     (state),
    .mole      (mole),
    .score     (score)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [7:0] pick(input logic [2:0] idx, input logic [7:0] cur);
    logic [2:0] s;
    s = idx;
    if (cur[s]) s = s + 3'd1;
    return 8'b0000_0001 << s;
  endfunction

  // Reference LFSR, tracks the DUT's random source cycle for cycle.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) m_lfsr <= SEED;
    else       m_lfsr <= lstep(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PLAY cycle with hole buttons h; updates the mole model and checks the mole.
  task automatic play_cycle(input logic [7:0] h, input string tag);
    logic [7:0] he;
    hit = h;
    he  = h & ~m_hitq;
    if (((he & m_mole) != 8'h00) || (m_cnt == MT - 1)) begin
      m_mole = pick(m_lfsr[2:0], m_mole);
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    m_hitq = h;
    tick();
    check(tag, {24'd0, mole}, {24'd0, m_mole});
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      play_cycle(m_mole, "hit_mole");
      play_cycle(8'h00, "release");
    end
  endtask

  // IDLE/OVER -> SET -> ARM -> PLAY with timeover low.
  task automatic go_play();
    btn_start = 1'b1; tick();
    btn_start = 1'b0; tick();
    btn_start = 1'b1; tick();
    btn_start = 1'b0;
    m_mole = pick(m_lfsr[2:0], 8'h00);
    tick();
    m_cnt  = 0;
    m_hitq = hit;
    check("go_play_state", {27'd0, state}, 32'd3);
    check("go_play_mole", {24'd0, mole}, {24'd0, m_mole});
  endtask

  initial begin
    rst_n = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; hit = 8'h00; timeover = 1'b0;
    m_mole = 8'h00; m_hitq = 8'h00; m_cnt = 0;
    tick(); tick();
    check("rst_state", {27'd0, state}, 32'd0);
    check("rst_mole", {24'd0, mole}, 32'h00);
    check("rst_score", {24'd0, score}, 32'h00);
    rst_n = 1'b0;
    tick();
    check("idle_hold", {27'd0, state}, 32'd0);

    // Start sequence
    btn_start = 1'b1; tick();
    check("to_set", {27'd0, state}, 32'd1);
    btn_start = 1'b0; tick();
    check("set_hold", {27'd0, state}, 32'd1);
    btn_start = 1'b1; tick();
    check("to_arm", {27'd0, state}, 32'd2);
    check("arm_mole", {24'd0, mole}, 32'h00);
    btn_start = 1'b0;
    m_mole = pick(m_lfsr[2:0], 8'h00);
    tick();
    m_cnt = 0; m_hitq = 8'h00;
    check("to_play", {27'd0, state}, 32'd3);
    check("play_score", {24'd0, score}, 32'h00);
    check("play_mole", {24'd0, mole}, {24'd0, m_mole});

    // Score to 09, then BCD carry to 10
    hits(9);
    check("score_09", {24'd0, score}, 32'h09);
    old_mole = m_mole;
    play_cycle(m_mole, "carry_mole");
    check("score_10", {24'd0, score}, 32'h10);
    check("new_mole_differs", {31'd0, mole != old_mole}, 32'd1);
    check("mole_onehot", {31'd0, $onehot(mole)}, 32'd1);
    play_cycle(hit, "held_press");
    check("held_no_score", {24'd0, score}, 32'h10);
    play_cycle(8'h00, "release2");
    play_cycle(~m_mole, "empty_holes");
    check("empty_no_score", {24'd0, score}, 32'h10);
    play_cycle(8'h00, "release3");

    // Relocation on expiry, no hits
    for (int i = 0; i < 9; i++) begin
      old_mole = m_mole;
      play_cycle(8'h00, "expire_mole");
      check("expire_onehot", {31'd0, $onehot(mole)}, 32'd1);
    end

    // Pause
    btn_pause = 1'b1;
`ifdef WHAC_PAUSE_EN
    tick();
    check("pause_state", {27'd0, state}, 32'd5);
    check("pause_mole", {24'd0, mole}, {24'd0, m_mole});
    btn_pause = 1'b0;
    hit = m_mole; tick();
    check("pause_hit_state", {27'd0, state}, 32'd5);
    check("pause_hit_score", {24'd0, score}, 32'h10);
    hit = 8'h00; tick(); tick();
    check("pause_frozen", {24'd0, mole}, {24'd0, m_mole});
    btn_pause = 1'b1; tick();
    check("resume_state", {27'd0, state}, 32'd3);
    check("resume_mole", {24'd0, mole}, {24'd0, m_mole});
    btn_pause = 1'b0;
    m_hitq = 8'h00;
`else
    play_cycle(8'h00, "pause_ignored_mole");
    check("pause_ignored", {27'd0, state}, 32'd3);
    btn_pause = 1'b0;
`endif
    play_cycle(8'h00, "post_pause");

    // timeover beats a same-cycle correct hit
    timeover = 1'b1; hit = m_mole; tick();
    check("over_state", {27'd0, state}, 32'd4);
    check("over_score", {24'd0, score}, 32'h10);
    check("over_mole", {24'd0, mole}, 32'h00);
    timeover = 1'b0; hit = 8'h00; tick();
    check("over_hold", {27'd0, state}, 32'd4);

    // Restart: score held through SET/ARM, cleared by ARM
    btn_start = 1'b1; tick();
    check("reset_to_set", {27'd0, state}, 32'd1);
    check("set_keeps_score", {24'd0, score}, 32'h10);
    btn_start = 1'b0; tick();
    btn_start = 1'b1; tick();
    check("arm_keeps_score", {24'd0, score}, 32'h10);
    btn_start = 1'b0;
    m_mole = pick(m_lfsr[2:0], 8'h00);
    tick();
    m_cnt = 0; m_hitq = 8'h00;
    check("arm_clear_score", {24'd0, score}, 32'h00);
    check("arm2_mole", {24'd0, mole}, {24'd0, m_mole});

    // Saturation at 99
    hits(99);
    check("score_99", {24'd0, score}, 32'h99);
    play_cycle(m_mole, "sat_mole");
    check("score_sat", {24'd0, score}, 32'h99);

    // ARM with time already zero goes straight to OVER
    timeover = 1'b1; tick();
    timeover = 1'b0;
    btn_start = 1'b1; tick();
    btn_start = 1'b0; tick();
    btn_start = 1'b1; timeover = 1'b1; tick();
    check("arm_t0_state", {27'd0, state}, 32'd2);
    btn_start = 1'b0; tick();
    check("arm_t0_over", {27'd0, state}, 32'd4);
    check("arm_t0_mole", {24'd0, mole}, 32'h00);
    check("arm_t0_score", {24'd0, score}, 32'h00);
    timeover = 1'b0;

    // Reset mid-PLAY
    go_play();
    hits(5);
    check("score_05", {24'd0, score}, 32'h05);
    #2 rst_n = 1'b1;
    #1;
    check("async_rst_state", {27'd0, state}, 32'd0);
    check("async_rst_mole", {24'd0, mole}, 32'h00);
    check("async_rst_score", {24'd0, score}, 32'h00);
    tick();
    check("rst_next_state", {27'd0, state}, 32'd0);
    rst_n = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
